// File: rtl/jpeg_idct_transpose_buffer.sv
// Multi-bank DIM x DIM transpose buffer between the IDCT row and column passes.
// Row-major writes fill a ring of banks; each full bank drains transposed or in write order.
module jpeg_idct_transpose_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DIM       = 8,
  parameter int unsigned NUM_BANKS = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       inport_valid_i,
  input  logic [DATA_W-1:0]          inport_data_i,
  input  logic                       inport_transpose_i,
  output logic                       inport_ready_o,
  output logic                       outport_valid_o,
  output logic [DATA_W-1:0]          outport_data_o,
  output logic                       outport_last_o,
  input  logic                       outport_ready_i,
  output logic [$clog2(NUM_BANKS):0] level_o
);

  localparam int unsigned LOG_DIM = $clog2(DIM);
  localparam int unsigned IDX_W   = 2 * LOG_DIM;
  localparam int unsigned BANK_W  = $clog2(NUM_BANKS);
  localparam int unsigned ADDR_W  = BANK_W + IDX_W;
  localparam int unsigned LVL_W   = BANK_W + 1;
  localparam int unsigned DEPTH   = NUM_BANKS * DIM * DIM;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM * DIM - 1);

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [NUM_BANKS-1:0] full_q, full_d;
  logic [NUM_BANKS-1:0] mode_q, mode_d;
  logic [BANK_W-1:0]    wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0]    rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [LVL_W-1:0]     level_q, level_d;

  logic              wr_acc;
  logic              rd_adv;
  logic              rd_fire;
  logic [IDX_W-1:0]  rd_off;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  assign inport_ready_o  = ~full_q[wr_bank_q];
  assign outport_valid_o = valid_q;
  assign outport_data_o  = data_q;
  assign outport_last_o  = last_q;
  assign level_o         = level_q;

  assign wr_acc  = inport_valid_i & inport_ready_o;
  assign rd_adv  = ~valid_q | outport_ready_i;
  assign rd_fire = rd_adv & full_q[rd_bank_q];

  // Transposed order swaps the row and column fields of the index: offset = c*DIM + r.
  assign rd_off  = mode_q[rd_bank_q] ? {rd_idx_q[LOG_DIM-1:0], rd_idx_q[IDX_W-1:LOG_DIM]}
                                     : rd_idx_q;
  assign wr_addr = {wr_bank_q, wr_idx_q};
  assign rd_addr = {rd_bank_q, rd_off};

  always_comb begin
    full_d    = full_q;
    mode_d    = mode_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    valid_d   = valid_q;
    last_d    = last_q;
    data_d    = data_q;
    level_d   = '0;

    if (wr_acc) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
      if (wr_idx_q == '0) begin
        mode_d[wr_bank_q] = inport_transpose_i;
      end
      if (wr_idx_q == IDX_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_idx_d          = '0;
        wr_bank_d         = wr_bank_q + BANK_W'(1);
      end
    end

    // The read data register doubles as the output register.
    if (rd_fire) begin
      data_d   = mem_q[rd_addr];
      valid_d  = 1'b1;
      last_d   = (rd_idx_q == IDX_LAST);
      rd_idx_d = rd_idx_q + IDX_W'(1);
      if (rd_idx_q == IDX_LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_idx_d          = '0;
        rd_bank_d         = rd_bank_q + BANK_W'(1);
      end
    end else if (rd_adv) begin
      valid_d = 1'b0;
    end

    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      level_d = level_d + LVL_W'(full_d[b]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      full_q    <= '0;
      mode_q    <= '0;
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      level_q   <= '0;
    end else begin
      full_q    <= full_d;
      mode_q    <= mode_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
      level_q   <= level_d;
    end
  end

  // Sample storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_addr] <= inport_data_i;
    end
  end

endmodule

// File: tb/tb_jpeg_idct_transpose_buffer.sv
// Self-checking bench for jpeg_idct_transpose_buffer (DIM=8, two banks).
// Scoreboard queue is filled when a block is written and drained by the output monitor.
module tb_jpeg_idct_transpose_buffer;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DIM       = 8;
  localparam int unsigned NUM_BANKS = 2;
  localparam int          BLK       = DIM * DIM;

  typedef struct { logic [31:0] data; logic last; } exp_t;
  typedef struct { int k; logic [31:0] val; logic last; } spot_t;
  typedef struct { logic [31:0] base; logic tr; int mode; } blk_vec_t;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              inport_valid_i = 1'b0;
  logic [DATA_W-1:0] inport_data_i = '0;
  logic              inport_transpose_i = 1'b0;
  logic              inport_ready_o;
  logic              outport_valid_o;
  logic [DATA_W-1:0] outport_data_o;
  logic              outport_last_o;
  logic              outport_ready_i = 1'b0;
  logic [1:0]        level_o;

  exp_t        sb[$];
  logic [31:0] log_data[$];
  int          log_cyc[$];
  exp_t        e;
  int tests_run = 0, tests_failed = 0;
  int cyc = 0, out_cnt = 0, acc_cnt = 0, last_acc_cyc = 0, first_valid_cyc = -1;
  int stall_mode = 0, lvl_bad = 0;
  bit lvl_watch = 0, hold_chk = 0;
  logic [31:0] hold_data;
  logic        hold_last;

  jpeg_idct_transpose_buffer #(.DATA_W(DATA_W), .DIM(DIM), .NUM_BANKS(NUM_BANKS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inport_valid_i(inport_valid_i), .inport_data_i(inport_data_i),
    .inport_transpose_i(inport_transpose_i), .inport_ready_o(inport_ready_o),
    .outport_valid_o(outport_valid_o), .outport_data_o(outport_data_o),
    .outport_last_o(outport_last_o), .outport_ready_i(outport_ready_i),
    .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Downstream ready patterns: 0 always, 1 never, 2 random, 3 repeating 1,0,0,1.
  always @(posedge clk_i) begin
    #1;
    case (stall_mode)
      0:       outport_ready_i = 1'b1;
      1:       outport_ready_i = 1'b0;
      2:       outport_ready_i = ($urandom_range(0, 3) != 0);
      default: outport_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endcase
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      hold_chk = 0;
    end else begin
      if (hold_chk) begin
        check("hold_valid", outport_valid_o, 1);
        check("hold_data", outport_data_o, hold_data);
        check("hold_last", outport_last_o, hold_last);
      end
      if (outport_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (lvl_watch && level_o != 2'd1) lvl_bad++;
      if (outport_valid_o && outport_ready_i) begin
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_output: got %0d, expected no output", outport_data_o);
        end else begin
          e = sb.pop_front();
          check("out_data", outport_data_o, e.data);
          check("out_last", outport_last_o, e.last);
        end
        log_data.push_back(outport_data_o);
        log_cyc.push_back(cyc);
        out_cnt++;
      end
      hold_chk  = outport_valid_o && !outport_ready_i;
      hold_data = outport_data_o;
      hold_last = outport_last_o;
    end
  end

  task automatic push_block(input logic [31:0] base, input logic tr);
    for (int k = 0; k < BLK; k++) begin
      exp_t x;
      int r = k / DIM;
      int c = k % DIM;
      x.data = tr ? base + 32'(c * DIM + r) : base + 32'(k);
      x.last = (k == BLK - 1);
      sb.push_back(x);
    end
  endtask

  // Entered and left at posedge+1; holds the sample until accepted or the budget runs out.
  task automatic write_sample(input logic [31:0] d, input logic tr, output bit ok);
    inport_valid_i     = 1'b1;
    inport_data_i      = d;
    inport_transpose_i = tr;
    ok = 0;
    for (int w = 0; w < 1000; w++) begin
      @(negedge clk_i);
      if (inport_ready_o) begin
        ok = 1;
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      @(posedge clk_i);
      #1;
      if (ok) break;
    end
  endtask

  task automatic write_block(input logic [31:0] base, input logic tr);
    bit ok;
    push_block(base, tr);
    for (int i = 0; i < BLK; i++) begin
      write_sample(base + 32'(i), tr, ok);
      if (!ok) begin
        tests_run++;
        tests_failed++;
        $display("FAIL write_timeout: sample %0d of block %0d not accepted", i, base);
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    for (int w = 0; w < 3000 && sb.size() != 0; w++) @(posedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_valid_drop"}, outport_valid_o, 0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_outputs(input int base, input int n);
    for (int w = 0; w < 2000 && (out_cnt - base) < n; w++) @(posedge clk_i);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, outport_valid_o, 0);
    check({name, "_data"}, outport_data_o, 0);
    check({name, "_last"}, outport_last_o, 0);
    check({name, "_level"}, level_o, 0);
    check({name, "_ready"}, inport_ready_o, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    spot_t    spots[7];
    blk_vec_t vecs[4];
    bit       ok;
    int       base_out, base_acc, extra, start_cyc;

    spots = '{'{0, 32'd0, 1'b0}, '{1, 32'd8, 1'b0}, '{7, 32'd56, 1'b0}, '{8, 32'd1, 1'b0},
              '{9, 32'd9, 1'b0}, '{62, 32'd55, 1'b0}, '{63, 32'd63, 1'b1}};
    vecs  = '{'{32'd2000, 1'b1, 2}, '{32'd3000, 1'b0, 3},
              '{32'd4000, 1'b1, 3}, '{32'd5000, 1'b0, 2}};

    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Single transposed block, downstream always ready.
    stall_mode = 0;
    log_data.delete();
    log_cyc.delete();
    first_valid_cyc = -1;
    write_block(0, 1'b1);
    inport_valid_i = 1'b0;
    wait_drain("t1");
    check("t1_latency", first_valid_cyc, last_acc_cyc + 2);
    check("t1_count", log_data.size(), BLK);
    foreach (spots[s]) begin
      if (log_data.size() > spots[s].k) check($sformatf("t1_spot%0d", spots[s].k), log_data[spots[s].k], spots[s].val);
    end

    // Bypass block then transposed block, back to back.
    log_data.delete();
    log_cyc.delete();
    write_block(100, 1'b0);
    write_block(200, 1'b1);
    inport_valid_i = 1'b0;
    wait_drain("t2");
    check("t2_count", log_data.size(), 2 * BLK);
    if (log_data.size() == 2 * BLK) begin
      check("t2_a_last", log_data[63], 163);
      check("t2_b_first", log_data[64], 200);
      check("t2_b_second", log_data[65], 208);
      check("t2_no_gap", log_cyc[64] - log_cyc[63], 1);
      check("t2_span", log_cyc[127] - log_cyc[0], 127);
    end

    // Both banks full with downstream stalled.
    stall_mode = 1;
    @(posedge clk_i);
    #1;
    base_acc = acc_cnt;
    write_block(0, 1'b1);
    write_block(1000, 1'b0);
    inport_valid_i = 1'b1;
    inport_data_i  = 32'd9999;
    extra = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (inport_ready_o) extra++;
    end
    @(posedge clk_i);
    #1;
    inport_valid_i = 1'b0;
    @(negedge clk_i);
    check("t3_accepted", acc_cnt - base_acc + extra, 128);
    check("t3_ready_low", inport_ready_o, 0);
    check("t3_level", level_o, 2);
    check("t3_valid", outport_valid_o, 1);
    check("t3_head_data", outport_data_o, 0);
    base_out = out_cnt;
    stall_mode = 0;
    wait_outputs(base_out, 32);
    @(negedge clk_i);
    check("t3_ready_mid", inport_ready_o, 0);
    wait_outputs(base_out, 64);
    @(negedge clk_i);
    check("t3_ready_back", inport_ready_o, 1);
    check("t3_level_after", level_o, 1);
    @(posedge clk_i);
    #1;
    wait_drain("t3");

    // Four blocks under stall patterns from the table.
    base_out = out_cnt;
    foreach (vecs[v]) begin
      stall_mode = vecs[v].mode;
      write_block(vecs[v].base, vecs[v].tr);
    end
    inport_valid_i = 1'b0;
    wait_drain("t4");
    check("t4_count", out_cnt - base_out, 4 * BLK);
    stall_mode = 0;

    // Reset during a partial write, then during readout.
    for (int i = 0; i < 20; i++) write_sample(32'd7000 + 32'(i), 1'b1, ok);
    inport_valid_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_outputs("t5_partial");
    sb.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    base_out = out_cnt;
    write_block(8000, 1'b0);
    inport_valid_i = 1'b0;
    wait_outputs(base_out, 10);
    @(posedge clk_i);
    #2;
    check("t5_pre_valid", outport_valid_o, 1);
    rst_i = 1'b0;
    #1;
    check_reset_outputs("t5_readout");
    sb.delete();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    log_data.delete();
    log_cyc.delete();
    write_block(300, 1'b1);
    inport_valid_i = 1'b0;
    wait_drain("t5");
    check("t5_count", log_data.size(), BLK);
    if (log_data.size() >= 2) begin
      check("t5_first", log_data[0], 300);
      check("t5_second", log_data[1], 308);
    end

    // Continuous streaming: write and read finish on the same edge.
    log_data.delete();
    log_cyc.delete();
    lvl_bad = 0;
    start_cyc = cyc;
    write_block(400, 1'b1);
    lvl_watch = 1;
    write_block(500, 1'b0);
    write_block(600, 1'b1);
    write_block(700, 1'b0);
    lvl_watch = 0;
    inport_valid_i = 1'b0;
    check("t6_write_span", last_acc_cyc - start_cyc, 4 * BLK - 1);
    check("t6_level_end", level_o, 1);
    wait_drain("t6");
    check("t6_level_stable", lvl_bad, 0);
    check("t6_count", log_data.size(), 4 * BLK);
    if (log_data.size() == 4 * BLK) check("t6_read_span", log_cyc[255] - log_cyc[0], 255);
    check("t6_level_empty", level_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
